fft_spectrum_analyzer: RTL

Streaming spectrum post-processor placed after the FFT output RAM. It consumes one complex FFT frame per pass and computes |X|^2 for each bin in the positive-frequency half. For every frame it reports the global peak bin and magnitude, per-band energies and per-band threshold flags. It generalises the single-peak detector with a parametrised width, FFT size and band count, and adds a result handshake.

---
 rtl/fft_spectrum_pkg.sv | 20 ++
 rtl/spectrum_mag_sq.sv | 55 +++++
 rtl/fft_spectrum_analyzer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fft_spectrum_pkg.sv
// Shared state type, pipeline depth and width helpers for the FFT spectrum post-processor.
package fft_spectrum_pkg;

   typedef enum logic [1:0] {
      COLLECT,
      DRAIN,
      PRESENT
   } spec_state_t;

   localparam int PIPE_DEPTH = 3;

   function automatic int mag_width(input int dw);
      return 2 * dw;
   endfunction

   function automatic int bin_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/spectrum_mag_sq.sv
// Two-stage |X|^2 pipeline: S1 squares re/im, S2 sums them; bin index rides along as a sideband.
module spectrum_mag_sq
   import fft_spectrum_pkg::*;
#(
   parameter int DATA_WIDTH = 18,
   parameter int BIN_WIDTH  = 8
) (
   input  logic                                clk,
   input  logic                                resetb,
   input  logic                                in_valid,
   input  logic signed [DATA_WIDTH-1:0]        re,
   input  logic signed [DATA_WIDTH-1:0]        im,
   input  logic [BIN_WIDTH-1:0]                in_bin,
   output logic                                mag_valid,
   output logic [mag_width(DATA_WIDTH)-1:0]    mag,
   output logic [BIN_WIDTH-1:0]                mag_bin
);
   localparam int MW = mag_width(DATA_WIDTH);

   logic signed [MW-1:0] re_prod;
   logic signed [MW-1:0] im_prod;
   logic [MW-1:0]        re_sq;
   logic [MW-1:0]        im_sq;
   logic                 s1_valid;
   logic [BIN_WIDTH-1:0] s1_bin;

   // A square of a signed value is never negative, so the sign bit is always clear.
   assign re_prod = re * re;
   assign im_prod = im * im;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         s1_valid  <= 1'b0;
         s1_bin    <= '0;
         re_sq     <= '0;
         im_sq     <= '0;
         mag_valid <= 1'b0;
         mag_bin   <= '0;
         mag       <= '0;
      end else begin
         s1_valid  <= in_valid;
         mag_valid <= s1_valid;
         if (in_valid) begin
            re_sq  <= $unsigned(re_prod);
            im_sq  <= $unsigned(im_prod);
            s1_bin <= in_bin;
         end
         if (s1_valid) begin
            mag     <= re_sq + im_sq;
            mag_bin <= s1_bin;
         end
      end
   end

endmodule

// File: rtl/fft_spectrum_analyzer.sv
// Per-frame peak search, band energies and threshold flags over the positive half of an FFT frame.
// Optional SPECTRUM_DC_SKIP_EN excludes bin 0 from the peak search and band 0's energy.
module fft_spectrum_analyzer
   import fft_spectrum_pkg::*;
#(
   parameter int DATA_WIDTH = 18,
   parameter int FFT_SIZE   = 256,
   parameter int NUM_BANDS  = 6,
   parameter int ACC_WIDTH  = 48
) (
   input  logic                               clk,
   input  logic                               resetb,
   input  logic signed [DATA_WIDTH-1:0]       bin_real_i,
   input  logic signed [DATA_WIDTH-1:0]       bin_imag_i,
   input  logic                               bin_valid_i,
   output logic                               bin_ready_o,
   input  logic [ACC_WIDTH-1:0]               threshold_i,
   output logic                               frame_valid_o,
   input  logic                               frame_ready_i,
   output logic [bin_width(FFT_SIZE)-1:0]     peak_bin_o,
   output logic [mag_width(DATA_WIDTH)-1:0]   peak_mag_o,
   output logic [NUM_BANDS*ACC_WIDTH-1:0]     band_energy_o,
   output logic [NUM_BANDS-1:0]               band_level_o,
   output logic [NUM_BANDS-1:0]               band_sat_o
);
   localparam int BW        = bin_width(FFT_SIZE);
   localparam int MW        = mag_width(DATA_WIDTH);
   localparam int HALF      = FFT_SIZE / 2;
   localparam int BAND_BINS = HALF / NUM_BANDS;
   localparam int BAND_IW   = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam int DCW       = $clog2(PIPE_DEPTH + 1);

   localparam logic [BW-1:0]      LAST_BIN   = BW'(FFT_SIZE - 1);
   localparam logic [BW-1:0]      HALF_BIN   = BW'(HALF);
   localparam logic [BW-1:0]      BAND_LAST  = BW'(BAND_BINS - 1);
   localparam logic [BAND_IW-1:0] LAST_BAND  = BAND_IW'(NUM_BANDS - 1);
   localparam logic [DCW-1:0]     DRAIN_LAST = DCW'(PIPE_DEPTH);

   spec_state_t          state;
   spec_state_t          next_state;
   logic [DCW-1:0]       drain_cnt;
   logic [BW-1:0]        bin_cnt;
   logic                 bin_fire;
   logic                 frame_fire;
   logic                 drain_done;

   logic                 mag_valid;
   logic [MW-1:0]        mag;
   logic [BW-1:0]        mag_bin;
   logic                 take;
   logic [BAND_IW-1:0]   band_idx;
   logic [BW-1:0]        band_ofs;
   logic [ACC_WIDTH-1:0] acc [NUM_BANDS];
   logic [ACC_WIDTH:0]   acc_sum;
   logic [MW-1:0]        peak_mag;
   logic [BW-1:0]        peak_bin;
   logic [NUM_BANDS-1:0] level;
   logic [NUM_BANDS-1:0] sat;

   always_comb begin
      next_state    = state;
      bin_ready_o   = 1'b0;
      frame_valid_o = 1'b0;
      case (state)
         COLLECT: begin
            bin_ready_o = 1'b1;
            if (bin_valid_i && bin_cnt == LAST_BIN) next_state = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt == DRAIN_LAST) next_state = PRESENT;
         end
         PRESENT: begin
            frame_valid_o = 1'b1;
            if (frame_ready_i) next_state = COLLECT;
         end
         default: next_state = COLLECT;
      endcase
   end

   assign bin_fire   = bin_valid_i && bin_ready_o;
   assign frame_fire = frame_valid_o && frame_ready_i;
   assign drain_done = (state == DRAIN) && (drain_cnt == DRAIN_LAST);

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state     <= COLLECT;
         bin_cnt   <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= next_state;
         drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
         if (bin_fire) bin_cnt <= bin_cnt + 1'b1;
      end
   end

   spectrum_mag_sq #(
      .DATA_WIDTH(DATA_WIDTH),
      .BIN_WIDTH (BW)
   ) u_mag_sq (
      .clk      (clk),
      .resetb   (resetb),
      .in_valid (bin_fire && (bin_cnt < HALF_BIN)),
      .re       (bin_real_i),
      .im       (bin_imag_i),
      .in_bin   (bin_cnt),
      .mag_valid(mag_valid),
      .mag      (mag),
      .mag_bin  (mag_bin)
   );

`ifdef SPECTRUM_DC_SKIP_EN
   assign take = mag_valid && (mag_bin != '0);
`else
   assign take = mag_valid;
`endif

   assign acc_sum = {1'b0, acc[band_idx]} + {{(ACC_WIDTH + 1 - MW){1'b0}}, mag};

   // Band counters advance for every in-window bin (even a skipped DC bin) so bands stay aligned.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         band_idx <= '0;
         band_ofs <= '0;
         peak_mag <= '0;
         peak_bin <= '0;
         sat      <= '0;
         for (int k = 0; k < NUM_BANDS; k++) acc[k] <= '0;
      end else if (frame_fire) begin
         band_idx <= '0;
         band_ofs <= '0;
         peak_mag <= '0;
         peak_bin <= '0;
         sat      <= '0;
         for (int k = 0; k < NUM_BANDS; k++) acc[k] <= '0;
      end else if (mag_valid) begin
         if (band_ofs == BAND_LAST && band_idx != LAST_BAND) begin
            band_idx <= band_idx + 1'b1;
            band_ofs <= '0;
         end else begin
            band_ofs <= band_ofs + 1'b1;
         end
         if (take) begin
            if (acc_sum[ACC_WIDTH]) begin
               acc[band_idx] <= '1;
               sat[band_idx] <= 1'b1;
            end else begin
               acc[band_idx] <= acc_sum[ACC_WIDTH-1:0];
            end
            if (mag > peak_mag) begin
               peak_mag <= mag;
               peak_bin <= mag_bin;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         level <= '0;
      end else if (frame_fire) begin
         level <= '0;
      end else if (drain_done) begin
         for (int k = 0; k < NUM_BANDS; k++) level[k] <= (acc[k] >= threshold_i);
      end
   end

   always_comb begin
      band_energy_o = '0;
      for (int k = 0; k < NUM_BANDS; k++) band_energy_o[k*ACC_WIDTH +: ACC_WIDTH] = acc[k];
   end

   assign peak_bin_o   = peak_bin;
   assign peak_mag_o   = peak_mag;
   assign band_level_o = level;
   assign band_sat_o   = sat;

endmodule
